// File: rtl/nclic_pkg.sv
// Shared types and default sizing for the interrupt controller slice.
// The upstream priority tree uses the same prio_t / irq_idx_t.
package nclic_pkg;

  localparam int DefNumIrq     = 16;
  localparam int DefPrioW      = 4;
  localparam int DefStackDepth = 8;
  localparam int DefIdxW       = $clog2(DefNumIrq);

  typedef logic [DefPrioW-1:0] prio_t;
  typedef logic [DefIdxW-1:0]  irq_idx_t;

  typedef enum logic {
    IDLE,
    REQ
  } dispatch_state_e;

endpackage

// File: rtl/prio_stack.sv
// LIFO of active {prio, id} entries.
// When pop and push happen in the same cycle, the pop goes first, so the top entry is replaced.
module prio_stack
  import nclic_pkg::*;
#(
  parameter int Width = 8,
  parameter int Depth = DefStackDepth,
  localparam int DepthW = $clog2(Depth + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [Width-1:0]  push_data,
  output logic [Width-1:0]  top,
  output logic [DepthW-1:0] depth,
  output logic              full,
  output logic              empty
);

  logic [Width-1:0]  mem [Depth];
  logic [DepthW-1:0] cnt_q;
  logic [DepthW-1:0] base;
  logic              do_pop;
  logic              do_push;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == DepthW'(Depth));
  assign depth   = cnt_q;
  assign do_pop  = pop && !empty;
  assign base    = do_pop ? cnt_q - DepthW'(1) : cnt_q;
  assign do_push = push && (do_pop || !full);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= do_push ? base + DepthW'(1) : base;
    end
  end

  // Entry storage needs no reset; the count alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < Depth; i++) begin
      if (do_push && (base == DepthW'(i))) begin
        mem[i] <= push_data;
      end
    end
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < Depth; i++) begin
      if (cnt_q == DepthW'(i + 1)) begin
        top = mem[i];
      end
    end
  end

endmodule

// File: rtl/nclic_dispatch.sv
// Dispatch and nesting stage: compares the tree winner with the running threshold,
// performs the req/ack handshake with the core, and tracks nesting on a priority stack.
module nclic_dispatch
  import nclic_pkg::*;
#(
  parameter int NumIrq     = DefNumIrq,
  parameter int PrioW      = DefPrioW,
  parameter int StackDepth = DefStackDepth,
  localparam int IdxW   = $clog2(NumIrq),
  localparam int DepthW = $clog2(StackDepth + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              win_valid,
  input  logic [IdxW-1:0]   win_id,
  input  logic [PrioW-1:0]  win_prio,
  output logic              irq_req,
  output logic [IdxW-1:0]   irq_id,
  output logic [PrioW-1:0]  irq_prio,
  input  logic              irq_ack,
  input  logic              irq_ret,
  output logic              clr_valid,
  output logic [IdxW-1:0]   clr_id,
  output logic [PrioW-1:0]  cur_prio,
  output logic [DepthW-1:0] depth,
  output logic              err_underflow
);

  localparam int EntryW = PrioW + IdxW;

  dispatch_state_e   state_q;
  dispatch_state_e   state_d;
  logic              latch;
  logic              push;
  logic              eligible;
  logic              full;
  logic              empty;
  logic [EntryW-1:0] top_entry;
  logic              unused_top_id;

  assign cur_prio      = top_entry[EntryW-1 -: PrioW];
  assign unused_top_id = ^top_entry[IdxW-1:0];
  assign eligible      = win_valid && (win_prio > cur_prio) && !full;
  assign irq_req       = (state_q == REQ);

  // A newer winner during REQ never replaces the latched request; it is re-evaluated after the ack.
  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (eligible) begin
          latch   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (irq_ack) begin
          push    = 1'b1;
          state_d = IDLE;
        end else if (!win_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      irq_id        <= '0;
      irq_prio      <= '0;
      clr_valid     <= 1'b0;
      clr_id        <= '0;
      err_underflow <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_valid <= push;
      if (latch) begin
        irq_id   <= win_id;
        irq_prio <= win_prio;
      end
      if (push) begin
        clr_id <= irq_id;
      end
      if (irq_ret && empty) begin
        err_underflow <= 1'b1;
      end
    end
  end

  prio_stack #(
    .Width (EntryW),
    .Depth (StackDepth)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (irq_ret),
    .push_data ({irq_prio, irq_id}),
    .top       (top_entry),
    .depth     (depth),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_nclic_dispatch.sv
// Self-checking bench for nclic_dispatch: a queue-based model is compared every cycle,
// and directed scenarios are pinned with hand-computed literal expectations.
module tb_nclic_dispatch;

  logic       clk = 1'b0;
  logic       reset;
  logic       win_valid;
  logic [3:0] win_id;
  logic [3:0] win_prio;
  logic       irq_req;
  logic [3:0] irq_id;
  logic [3:0] irq_prio;
  logic       irq_ack;
  logic       irq_ret;
  logic       clr_valid;
  logic [3:0] clr_id;
  logic [3:0] cur_prio;
  logic [3:0] depth;
  logic       err_underflow;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  // Behavioural model state: active priorities as a queue, plus the outstanding request.
  int   m_stk[$];
  bit   m_req, m_clr, m_err;
  int   m_id, m_prio, m_clr_id;
  int   m_cur_before, m_size_before;

  nclic_dispatch dut (
    .clk           (clk),
    .reset         (reset),
    .win_valid     (win_valid),
    .win_id        (win_id),
    .win_prio      (win_prio),
    .irq_req       (irq_req),
    .irq_id        (irq_id),
    .irq_prio      (irq_prio),
    .irq_ack       (irq_ack),
    .irq_ret       (irq_ret),
    .clr_valid     (clr_valid),
    .clr_id        (clr_id),
    .cur_prio      (cur_prio),
    .depth         (depth),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic wv, input logic [3:0] id,
                               input logic [3:0] prio, input logic ack, input logic ret);
    reset     = rst;
    win_valid = wv;
    win_id    = id;
    win_prio  = prio;
    irq_ack   = ack;
    irq_ret   = ret;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_req = 0; m_clr = 0; m_err = 0;
      m_id = 0; m_prio = 0; m_clr_id = 0;
      m_stk.delete();
    end else begin
      m_size_before = m_stk.size();
      m_cur_before  = (m_size_before > 0) ? m_stk[$] : 0;
      m_clr = 0;
      if (irq_ret) begin
        if (m_size_before > 0) void'(m_stk.pop_back());
        else m_err = 1;
      end
      if (m_req) begin
        if (irq_ack) begin
          m_stk.push_back(m_prio);
          m_clr    = 1;
          m_clr_id = m_id;
          m_req    = 0;
        end else if (!win_valid) begin
          m_req = 0;
        end
      end else if (win_valid && int'(win_prio) > m_cur_before && m_size_before < 8) begin
        m_req  = 1;
        m_id   = win_id;
        m_prio = win_prio;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model irq_req", irq_req, m_req);
      checkOutput("model clr_valid", clr_valid, m_clr);
      checkOutput("model depth", depth, m_stk.size());
      checkOutput("model cur_prio", cur_prio, (m_stk.size() > 0) ? m_stk[$] : 0);
      checkOutput("model err_underflow", err_underflow, m_err);
      if (m_req) begin
        checkOutput("model irq_id", irq_id, m_id);
        checkOutput("model irq_prio", irq_prio, m_prio);
      end
      if (m_clr) checkOutput("model clr_id", clr_id, m_clr_id);
    end
  end

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    check_en = 1'b1;
    checkOutput("reset irq_req", irq_req, 0);
    checkOutput("reset irq_id", irq_id, 0);
    checkOutput("reset depth", depth, 0);
    checkOutput("reset cur_prio", cur_prio, 0);
    checkOutput("reset err", err_underflow, 0);

    // Basic take
    applyStimulus(0, 1, 5, 3, 0, 0);
    checkOutput("take irq_req", irq_req, 1);
    checkOutput("take irq_id", irq_id, 5);
    applyStimulus(0, 1, 5, 3, 1, 0);
    checkOutput("take clr_valid", clr_valid, 1);
    checkOutput("take clr_id", clr_id, 5);
    checkOutput("take cur_prio", cur_prio, 3);
    checkOutput("take depth", depth, 1);
    checkOutput("take req low", irq_req, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("take clr one cycle", clr_valid, 0);

    // Nesting
    applyStimulus(0, 1, 9, 3, 0, 0);
    checkOutput("nest equal prio", irq_req, 0);
    applyStimulus(0, 1, 9, 6, 0, 0);
    checkOutput("nest req id", irq_id, 9);
    applyStimulus(0, 1, 9, 6, 1, 0);
    checkOutput("nest depth", depth, 2);
    checkOutput("nest cur_prio", cur_prio, 6);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("ret1 cur_prio", cur_prio, 3);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("ret2 cur_prio", cur_prio, 0);
    checkOutput("ret2 depth", depth, 0);

    // Underflow
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("underflow err", err_underflow, 1);
    checkOutput("underflow depth", depth, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("underflow sticky", err_underflow, 1);

    // Withdraw, then ack together with !win_valid
    applyStimulus(0, 1, 2, 4, 0, 0);
    applyStimulus(0, 0, 2, 4, 0, 0);
    checkOutput("withdraw req", irq_req, 0);
    checkOutput("withdraw clr", clr_valid, 0);
    applyStimulus(0, 1, 2, 4, 0, 0);
    applyStimulus(0, 0, 2, 4, 1, 0);
    checkOutput("ackwins clr", clr_valid, 1);
    checkOutput("ackwins depth", depth, 1);

    // Simultaneous ack and return
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 1, 2, 0, 0);
    applyStimulus(0, 1, 1, 2, 1, 0);
    applyStimulus(0, 1, 7, 4, 0, 0);
    checkOutput("ackret req id", irq_id, 7);
    applyStimulus(0, 1, 7, 4, 1, 1);
    checkOutput("ackret depth", depth, 1);
    checkOutput("ackret cur_prio", cur_prio, 4);
    checkOutput("ackret clr_id", clr_id, 7);

    // Reset while in REQ
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 3, 5, 0, 0);
    checkOutput("prereset req", irq_req, 1);
    applyStimulus(1, 1, 3, 5, 0, 0);
    checkOutput("midreset req", irq_req, 0);
    checkOutput("midreset irq_id", irq_id, 0);
    checkOutput("midreset irq_prio", irq_prio, 0);
    checkOutput("midreset err", err_underflow, 0);
    checkOutput("midreset depth", depth, 0);

    // Higher winner during REQ does not replace the latched request
    applyStimulus(0, 1, 4, 4, 0, 0);
    applyStimulus(0, 1, 11, 9, 0, 0);
    checkOutput("hold irq_id", irq_id, 4);
    applyStimulus(0, 1, 11, 9, 1, 0);
    checkOutput("hold clr_id", clr_id, 4);
    applyStimulus(0, 1, 11, 9, 0, 0);
    checkOutput("reeval irq_id", irq_id, 11);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);

    // Fill the stack to its 8-entry limit
    for (int p = 1; p <= 8; p++) begin
      applyStimulus(0, 1, 4'(p), 4'(p), 0, 0);
      applyStimulus(0, 1, 4'(p), 4'(p), 1, 0);
    end
    checkOutput("full depth", depth, 8);
    checkOutput("full cur_prio", cur_prio, 8);
    applyStimulus(0, 1, 15, 15, 0, 0);
    checkOutput("full no req", irq_req, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("idle ack ignored", clr_valid, 0);
    checkOutput("idle ack depth", depth, 8);
    for (int k = 0; k < 8; k++) applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("drain depth", depth, 0);
    checkOutput("drain err", err_underflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
